// File: rtl/tdr_scan_driver.sv
// Initiator for the TDR scan access protocol: sequences capture -> shift -> update on a target
// chain for one request and returns the bits shifted out.
module tdr_scan_driver #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [LEN_W-1:0]   i_req_len,
    input  logic [MAX_LEN-1:0] i_req_wdata,
    input  logic               i_req_capture,
    input  logic               i_req_update,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [MAX_LEN-1:0] o_rsp_rdata,
    output logic               o_busy,
    output logic               o_select,
    output logic               o_capture_en,
    output logic               o_shift_en,
    output logic               o_update_en,
    output logic               o_si,
    input  logic               i_so
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_k;
    logic [MAX_LEN-1:0] r_wdata;
    logic [MAX_LEN-1:0] r_rdata;
    logic               r_upd;
    logic               r_select;
    logic               r_capture_en;
    logic               r_shift_en;
    logic               r_update_en;
    logic               r_si;

    logic [LEN_W-1:0]   w_len_c;
    logic               w_accept;
    logic               w_last_shift;
    logic               w_si;

    assign w_len_c      = (i_req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_req_len;
    assign w_accept     = (r_state == S_IDLE) && i_req_valid;
    assign w_last_shift = (r_k == r_len - LEN_W'(1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_si   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (i_req_capture)        w_next = S_CAPTURE;
                    else if (w_len_c != '0)   w_next = S_SHIFT;
                    else if (i_req_update)    w_next = S_UPDATE;
                    else                      w_next = S_RESP;
                end
            end
            S_CAPTURE: begin
                if (r_len != '0)   w_next = S_SHIFT;
                else if (r_upd)    w_next = S_UPDATE;
                else               w_next = S_RESP;
            end
            S_SHIFT: begin
                if (w_last_shift)  w_next = r_upd ? S_UPDATE : S_RESP;
            end
            S_UPDATE: w_next = S_RESP;
            S_RESP: begin
                if (i_rsp_ready)   w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // si is registered, so present the bit for the upcoming shift cycle
        if (w_next == S_SHIFT) begin
            case (r_state)
                S_IDLE:    w_si = i_req_wdata[0];
                S_CAPTURE: w_si = r_wdata[0];
                default:   w_si = r_wdata[1];
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_len        <= '0;
            r_k          <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_upd        <= 1'b0;
            r_select     <= 1'b0;
            r_capture_en <= 1'b0;
            r_shift_en   <= 1'b0;
            r_update_en  <= 1'b0;
            r_si         <= 1'b0;
        end else begin
            r_select     <= (w_next == S_CAPTURE) || (w_next == S_SHIFT) || (w_next == S_UPDATE);
            r_capture_en <= (w_next == S_CAPTURE);
            r_shift_en   <= (w_next == S_SHIFT);
            r_update_en  <= (w_next == S_UPDATE);
            r_si         <= w_si;
            if (w_accept) begin
                r_len   <= w_len_c;
                r_wdata <= i_req_wdata;
                r_upd   <= i_req_update;
                r_rdata <= '0;
                r_k     <= '0;
            end else if (r_state == S_SHIFT) begin
                // r_wdata[0] always holds the bit currently on si
                r_rdata[r_k[IDX_W-1:0]] <= i_so;
                r_k                     <= r_k + LEN_W'(1);
                r_wdata                 <= r_wdata >> 1;
            end
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_rsp_rdata  = r_rdata;
    assign o_select     = r_select;
    assign o_capture_en = r_capture_en;
    assign o_shift_en   = r_shift_en;
    assign o_update_en  = r_update_en;
    assign o_si         = r_si;

endmodule
